// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC reader.
package adc_pkg;

  localparam int ADC_DATA_W        = 12;
  localparam int ADC_FRAME_BITS    = 16;
  localparam int ADC_QUIET_DEFAULT = 4;
  localparam int ADC_DIV_W         = 12;
  localparam int ADC_TOGGLES       = 2 * ADC_FRAME_BITS;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    QUIET
  } adc_state_e;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period timer for sclk: counts 0..div_q while run is high, ticks on the last count.
module sclk_tick_gen
  import adc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [ADC_DIV_W-1:0] div_q,
  output logic                 tick
);

  logic [ADC_DIV_W-1:0] cnt;

  assign tick = run && (cnt == div_q);

  // Wraps on tick, so div_q = 4095 never needs a 13th bit.
  always_ff @(posedge clk) begin
    if (rst || !run || tick) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/adc_serial_reader.sv
// Serial ADC frame reader: drives cs_n/sclk, shifts in a 16-bit frame (4 zeros + 12 data bits).
//  state | meaning
//  IDLE  | cs_n high, waiting for enable
//  SETUP | cs_n low, sclk high for one half-period before the first falling edge
//  SHIFT | 32 sclk toggles; sdata captured on every rising toggle
//  QUIET | cs_n high for QUIET_CYCLES between frames
module adc_serial_reader
  import adc_pkg::*;
#(
  parameter int QUIET_CYCLES = ADC_QUIET_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [ADC_DIV_W-1:0]  div,
  input  logic                  sdata,
  output logic                  cs_n,
  output logic                  sclk,
  output logic [ADC_DATA_W-1:0] sample_data,
  output logic                  sample_valid,
  output logic                  frame_err
);

  localparam int              QW       = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam logic [QW-1:0]   Q_LOAD   = QW'(QUIET_CYCLES - 1);
  localparam logic [4:0]      LAST_TOG = 5'(ADC_TOGGLES - 1);

  adc_state_e                state, state_nxt;
  logic [ADC_DIV_W-1:0]      div_q;
  logic [4:0]                tog_cnt;
  logic [QW-1:0]             q_cnt;
  logic [ADC_FRAME_BITS-1:0] shift_q;
  logic [ADC_FRAME_BITS-1:0] shift_nxt;
  logic                      tick;
  logic                      run;
  logic                      frame_done;
  logic                      unused_shift_msb;

  assign run              = (state == SETUP) || (state == SHIFT);
  assign shift_nxt        = {shift_q[ADC_FRAME_BITS-2:0], sdata};
  assign frame_done       = (state == SHIFT) && tick && (tog_cnt == LAST_TOG);
  // The last bit arrives on the same edge the sample is published, so the oldest bit is never read.
  assign unused_shift_msb = shift_q[ADC_FRAME_BITS-1];

  sclk_tick_gen u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .div_q (div_q),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (frame_done) state_nxt = QUIET;
      QUIET:   if (q_cnt == '0) state_nxt = enable ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n         <= 1'b1;
      sclk         <= 1'b1;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      div_q        <= '0;
      tog_cnt      <= '0;
      q_cnt        <= '0;
      shift_q      <= '0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      cs_n         <= !((state_nxt == SETUP) || (state_nxt == SHIFT));

      if ((state != SETUP) && (state_nxt == SETUP)) div_q <= div;

      if ((state == SHIFT) && tick) begin
        sclk    <= ~sclk;
        tog_cnt <= tog_cnt + 5'd1;
        if (!sclk) shift_q <= shift_nxt;
      end

      if (frame_done) begin
        sample_data  <= shift_nxt[ADC_DATA_W-1:0];
        sample_valid <= 1'b1;
        frame_err    <= |shift_nxt[ADC_FRAME_BITS-1:ADC_DATA_W];
        q_cnt        <= Q_LOAD;
      end else if ((state == QUIET) && (q_cnt != '0)) begin
        q_cnt <= q_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader: ADC frame model feeding sdata, scoreboard of expected samples.
module tb_adc_serial_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] div = 12'd0;
  logic        sdata = 1'b0;
  logic        cs_n, sclk, sample_valid, frame_err;
  logic [11:0] sample_data;

  adc_serial_reader #(.QUIET_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .div          (div),
    .sdata        (sdata),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  logic [15:0] stim_q[$];
  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  logic [15:0] adc_frame = 16'h0000;
  int          bit_idx = 15;
  int          frames_started = 0;

  // ADC model: new frame on cs_n fall, next bit presented on each sclk fall.
  always @(negedge cs_n) begin
    adc_frame = (stim_q.size() > 0) ? stim_q.pop_front() : 16'h0000;
    exp_q.push_back({|adc_frame[15:12], adc_frame[11:0]});
    bit_idx = 15;
    frames_started++;
  end

  always @(negedge sclk) begin
    if (cs_n === 1'b0 && bit_idx >= 0) begin
      sdata = adc_frame[bit_idx];
      bit_idx--;
    end
  end

  int   valid_cnt = 0;
  int   low_run = 0, last_low = 0, hi_run = 0, last_gap = 0;
  int   rises = 0, last_rises = 0;
  int   lo_run = 0, lo_min = 1000, lo_max = 0;
  int   per_run = 0, per_min = 1000, per_max = 0;
  logic prev_sclk = 1'b1, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      got_q.push_back({frame_err, sample_data});
      valid_cnt++;
    end
    if (sclk === 1'b0) lo_run++;
    else if (prev_sclk === 1'b0) begin
      rises++;
      if (lo_run < lo_min) lo_min = lo_run;
      if (lo_run > lo_max) lo_max = lo_run;
      lo_run = 0;
      if (rises > 1) begin
        if (per_run < per_min) per_min = per_run;
        if (per_run > per_max) per_max = per_run;
      end
      per_run = 0;
    end
    per_run++;
    if (cs_n === 1'b0) begin
      if (prev_cs === 1'b1) begin
        last_gap = hi_run;
        rises = 0;
      end
      low_run++;
      hi_run = 0;
    end else begin
      if (prev_cs === 1'b0) begin
        last_low   = low_run;
        last_rises = rises;
      end
      low_run = 0;
      hi_run++;
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
  end

  task automatic clear_stats();
    rises = 0; lo_min = 1000; lo_max = 0; per_min = 1000; per_max = 0; lo_run = 0; per_run = 0;
  endtask

  task automatic wait_valid(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rises(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rises >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frames_started >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_enable();
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ncmp++; if (cs_n !== 1'b1) begin nerr++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    ncmp++; if (sclk !== 1'b1) begin nerr++; $display("FAIL reset_sclk: got %b expected 1", sclk); end
    ncmp++; if (sample_data !== 12'h000) begin nerr++; $display("FAIL reset_data: got %h expected 000", sample_data); end
    ncmp++; if (sample_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    ncmp++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int v0; logic [12:0] g, e;
    clear_stats(); v0 = valid_cnt; div = 12'd0;
    stim_q.push_back(16'h0ABC);
    pulse_enable();
    wait_valid(v0 + 1, 400, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL basic_timeout: got %0d valids expected %0d", valid_cnt - v0, 1); end
    repeat (20) @(negedge clk);
    ncmp++; if (valid_cnt !== v0 + 1) begin nerr++; $display("FAIL basic_pulses: got %0d expected 1", valid_cnt - v0); end
    ncmp++; if (last_low !== 33) begin nerr++; $display("FAIL basic_cs_low: got %0d expected 33", last_low); end
    ncmp++; if (sample_data !== 12'hABC) begin nerr++; $display("FAIL basic_hold: got %h expected abc", sample_data); end
    ncmp++; if (cs_n !== 1'b1) begin nerr++; $display("FAIL basic_idle_cs: got %b expected 1", cs_n); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
      ncmp++; if (g !== e) begin nerr++; $display("FAIL basic_sample: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_frame_err();
    bit ok; int v0; logic [12:0] g, e;
    v0 = valid_cnt; div = 12'd0;
    stim_q.push_back(16'h1FFF);
    pulse_enable();
    wait_valid(v0 + 1, 400, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL err_timeout: got %0d valids expected 1", valid_cnt - v0); end
    repeat (20) @(negedge clk);
    ncmp++; if (sample_data !== 12'hFFF) begin nerr++; $display("FAIL err_data: got %h expected fff", sample_data); end
    ncmp++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL err_pulse_len: got %b expected 0", frame_err); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h0000;
      ncmp++; if (g !== e) begin nerr++; $display("FAIL err_sample: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_div3();
    bit ok; int v0; logic [12:0] g, e;
    clear_stats(); v0 = valid_cnt; div = 12'd3;
    stim_q.push_back(16'h0A5C);
    pulse_enable();
    div = 12'd0;  // must not take effect until the next frame
    wait_valid(v0 + 1, 600, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL div3_timeout: got %0d valids expected 1", valid_cnt - v0); end
    repeat (10) @(negedge clk);
    ncmp++; if (lo_min !== 4 || lo_max !== 4) begin nerr++; $display("FAIL div3_low: got %0d..%0d expected 4", lo_min, lo_max); end
    ncmp++; if (per_min !== 8 || per_max !== 8) begin nerr++; $display("FAIL div3_period: got %0d..%0d expected 8", per_min, per_max); end
    ncmp++; if (last_rises !== 16) begin nerr++; $display("FAIL div3_rises: got %0d expected 16", last_rises); end
    ncmp++; if (last_low !== 132) begin nerr++; $display("FAIL div3_cs_low: got %0d expected 132", last_low); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
      ncmp++; if (g !== e) begin nerr++; $display("FAIL div3_sample: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int v0, f0; logic [12:0] g, e;
    clear_stats(); v0 = valid_cnt; f0 = frames_started; div = 12'd0;
    stim_q.push_back(16'h0123);
    stim_q.push_back(16'h0456);
    @(negedge clk) enable = 1'b1;
    wait_frames(f0 + 2, 400, ok);
    enable = 1'b0;
    ncmp++; if (!ok) begin nerr++; $display("FAIL b2b_start: got %0d frames expected 2", frames_started - f0); end
    wait_valid(v0 + 2, 400, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL b2b_timeout: got %0d valids expected 2", valid_cnt - v0); end
    repeat (20) @(negedge clk);
    ncmp++; if (last_gap !== 4) begin nerr++; $display("FAIL b2b_gap: got %0d expected 4", last_gap); end
    ncmp++; if (last_low !== 33) begin nerr++; $display("FAIL b2b_cs_low: got %0d expected 33", last_low); end
    ncmp++; if (frames_started !== f0 + 2) begin nerr++; $display("FAIL b2b_frames: got %0d expected 2", frames_started - f0); end
    ncmp++; if (got_q.size() !== 2) begin nerr++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
      ncmp++; if (g !== e) begin nerr++; $display("FAIL b2b_sample: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_enable_drop();
    bit ok; int v0, f0; logic [12:0] g, e;
    clear_stats(); v0 = valid_cnt; f0 = frames_started; div = 12'd1;
    stim_q.push_back(16'h0321);
    @(negedge clk) enable = 1'b1;
    wait_rises(5, 400, ok);
    enable = 1'b0;
    ncmp++; if (!ok) begin nerr++; $display("FAIL drop_rises: got %0d expected 5", rises); end
    wait_valid(v0 + 1, 400, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL drop_timeout: got %0d valids expected 1", valid_cnt - v0); end
    repeat (20) @(negedge clk);
    ncmp++; if (last_rises !== 16) begin nerr++; $display("FAIL drop_rises_total: got %0d expected 16", last_rises); end
    ncmp++; if (frames_started !== f0 + 1) begin nerr++; $display("FAIL drop_frames: got %0d expected 1", frames_started - f0); end
    ncmp++; if (cs_n !== 1'b1 || sclk !== 1'b1) begin nerr++; $display("FAIL drop_idle: got cs_n=%b sclk=%b expected 1 1", cs_n, sclk); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
      ncmp++; if (g !== e) begin nerr++; $display("FAIL drop_sample: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_rst_mid();
    bit ok; int v0;
    clear_stats(); v0 = valid_cnt; div = 12'd1;
    stim_q.push_back(16'h0777);
    @(negedge clk) enable = 1'b1;
    wait_rises(8, 400, ok);
    ncmp++; if (!ok) begin nerr++; $display("FAIL rst_rises: got %0d expected 8", rises); end
    rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    ncmp++; if (cs_n !== 1'b1) begin nerr++; $display("FAIL rst_cs_n: got %b expected 1", cs_n); end
    ncmp++; if (sclk !== 1'b1) begin nerr++; $display("FAIL rst_sclk: got %b expected 1", sclk); end
    ncmp++; if (sample_data !== 12'h000) begin nerr++; $display("FAIL rst_data: got %h expected 000", sample_data); end
    ncmp++; if (sample_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b expected 0", sample_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    ncmp++; if (valid_cnt !== v0) begin nerr++; $display("FAIL rst_no_valid: got %0d valids expected 0", valid_cnt - v0); end
    ncmp++; if (exp_q.size() !== 1) begin nerr++; $display("FAIL rst_pending: got %0d expected 1", exp_q.size()); end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_div3();
    test_back_to_back();
    test_enable_drop();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
ADC_SERIAL_READER -- requirements
Module: adc_serial_reader

Interface
REQ-001 The block SHALL have parameter QUIET_CYCLES, default 4, meaning the number of clk cycles cs_n is held high between frames.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port enable, input, 1 bit: run conversions continuously while high.
REQ-005 The block SHALL have port div, input, 12 bits: sclk half-period minus one, in clk cycles.
REQ-006 The block SHALL have port sdata, input, 1 bit: ADC serial data, MSB first.
REQ-007 The block SHALL have port cs_n, output, 1 bit: ADC chip select, active-low.
REQ-008 The block SHALL have port sclk, output, 1 bit: ADC serial clock; idles high.
REQ-009 The block SHALL have port sample_data, output, 12 bits: last received sample.
REQ-010 The block SHALL have port sample_valid, output, 1 bit: one-cycle pulse when sample_data updates.
REQ-011 The block SHALL have port frame_err, output, 1 bit: pulse coincident with sample_valid when any of the 4 leading frame bits is nonzero.

Function
REQ-012 Frame format SHALL be 16 bits: 4 leading zeros followed by 12 data bits, MSB first.
REQ-013 The FSM SHALL have states IDLE, SETUP, SHIFT and QUIET.
REQ-014 IDLE: cs_n=1, sclk=1; if enable=1, the FSM SHALL go to SETUP on the next clk edge.
REQ-015 On SETUP entry, the block SHALL latch div into div_q; div changes mid-frame SHALL have no effect until the next SETUP.
REQ-016 SETUP: cs_n=0, sclk=1 for div_q+1 cycles, then the FSM SHALL go to SHIFT.
REQ-017 A half-period counter SHALL count 0..div_q and emit a tick at div_q; in SHIFT, each tick SHALL toggle sclk.
REQ-018 SHIFT SHALL contain exactly 32 toggles (16 falling, 16 rising), with sclk high and low for div_q+1 cycles each.
REQ-019 On the clk edge where sclk goes 0->1, sdata SHALL be shifted into a 16-bit shift register.
REQ-020 After the 16th rising toggle, the FSM SHALL enter QUIET, with cs_n=1 and sclk=1.
REQ-021 On the same cycle, sample_data SHALL take shift[11:0], sample_valid SHALL be 1 for one cycle, and frame_err SHALL be (shift[15:12]!=0) for that cycle.
REQ-022 QUIET SHALL last QUIET_CYCLES cycles, then go to SETUP if enable=1, else IDLE.
REQ-023 enable deasserting during SETUP or SHIFT SHALL NOT abort the frame; the frame completes and the FSM then goes to IDLE.
REQ-024 cs_n low time per frame SHALL be (div_q+1)*33 cycles; div=0 SHALL give sclk = clk/2.
REQ-025 div=4095 SHALL work without overflow; the counter SHALL be 12 bits wide.
REQ-026 sample_data SHALL hold its value between valid pulses.

Reset
REQ-027 When rst=1, the block SHALL set state=IDLE, cs_n=1, sclk=1, sample_data=0, sample_valid=0, frame_err=0, and clear all counters and the shift register.
REQ-028 rst asserted mid-frame SHALL abort the frame, raise cs_n on the next edge, and produce no sample_valid.

Structure
REQ-029 Package adc_pkg SHALL hold the state enum, ADC_DATA_W=12, ADC_FRAME_BITS=16 and ADC_QUIET_DEFAULT=4.
REQ-030 The half-period tick counter SHALL be sub-module sclk_tick_gen (inputs clk, rst, run, div_q; output tick).
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 Bench SHALL check: div=0, ADC model frame 0x0ABC -> sample_data=0xABC, one valid pulse, frame_err=0, cs_n low 33 cycles.
REQ-033 Bench SHALL check: frame 0x1FFF -> sample_data=0xFFF, frame_err=1 with valid.
REQ-034 Bench SHALL check: div=3 -> sclk high/low 4 cycles each, 16 rising edges per frame, cs_n low 132 cycles.
REQ-035 Bench SHALL check: enable held high, QUIET_CYCLES=4 -> back-to-back frames with a 4-cycle cs_n-high gap; samples 0x123 then 0x456 are received in order.
REQ-036 Bench SHALL check: enable dropped after the 5th rising edge -> frame completes, valid fires, then IDLE with cs_n=1.
REQ-037 Bench SHALL check: rst pulsed after the 8th rising edge -> cs_n=1 and sclk=1 next cycle, no valid, sample_data=0.
